maindec_pipe: RTL and testbench
===============================

# maindec_pipe

Parametrised main decoder with pipelined control transport for the 5-stage MIPS core. Decodes the D-stage instruction into a 13-bit control word, adding sub-word load/store size and sign fields and an illegal-opcode flag. It carries that word, plus the destination register, through E/M/W registers with stall and flush control. It also detects load-use hazards for the hazard unit.

## Interface
- `LU_DETECT`, 1: 1 enables load-use detection; 0 ties `lu_stall` to 0.
- `EXT_MEM`, 1: 1 decodes LH/LHU/LB/LBU/SH/SB; 0 treats those opcodes as illegal.

- `clk`  in  1  core clock; all registers update on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instrD`  in  32  D-stage instruction: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11].
- `stallE`  in  1  holds the E register and inserts a bubble into M.
- `flushE`  in  1  loads a bubble into E.
- `flushM`  in  1  loads a bubble into M.
- `ctrlE`, `ctrlM`, `ctrlW`  out  13  registered control words for stages E, M and W.
- `writeregE`, `writeregM`, `writeregW`  out  5  registered destination register.
- `lu_stall`  out  1  combinational load-use hazard indication.

## Operation
Control word bit layout:
- [12] regwrite, [11] regdst, [10] alusrc, [9] branch, [8] memwrite, [7] memtoreg, [6] jump
- [5:4] aluop, [3:2] memsize (00 word, 01 half, 10 byte), [1] memsign, [0] illegal

Decode of op; unlisted fields are 0:
- 000000 (R-type): regwrite, regdst, aluop=10 → 0x1820.
- LW 100011 → 0x1480.
- LH 100001: memsize=01, memsign=1 → 0x1486.
- LHU 100101 → 0x1484.
- LB 100000: memsize=10, memsign=1 → 0x148A.
- LBU 100100 → 0x1488.
- SW 101011 → 0x0500; SH 101001 → 0x0504; SB 101000 → 0x0508.
- BEQ 000100: branch, aluop=01 → 0x0210.
- J 000010 → 0x0040.
- ADDI, ADDIU, SLTI, SLTIU (001000–001011): regwrite, alusrc, aluop=00 → 0x1400.
- ANDI, ORI, XORI, LUI (001100–001111): regwrite, alusrc, aluop=11 (ALU decoder selects by op) → 0x1430.
- Any other op, or a sub-word op with `EXT_MEM`=0: 0x0001. All enables are low, so no write side effects.

Destination register: `writereg` = regdst ? rd : rt, computed from `instrD` when the word is loaded into E.

A bubble is ctrl=0x0000 with writereg=0.

Register update per cycle, in priority order:
- E: rst → bubble; else flushE → bubble; else stallE → hold; else load the decoded word.
- M: rst → bubble; else flushM → bubble; else stallE → bubble; else copy E.
- W: rst → bubble; else copy M. W is never stalled or flushed.

`lu_stall` = `LU_DETECT` & ctrlE[7] & (writeregE≠0) & (writeregE==rs_D | writeregE==rt_D).
- The compare always includes rt_D, even when the D instruction does not read rt (conservative).
- The block does not act on `lu_stall` itself. The hazard unit returns stall/flush to this block.

## Timing
- Decode-to-E latency is 1 cycle. E→M and M→W are 1 cycle each.
- `lu_stall` is combinational from the E registers and `instrD`; it is valid in the same cycle.
- Reset: all ctrl and writereg outputs are 0 on the first edge with rst=1. `lu_stall` is therefore 0.
- Reset mid-stream clears all three stages on one edge; nothing in flight survives.
- flushE and stallE together: flushE wins, E becomes a bubble, M also becomes a bubble.
- flushM and stallE together: M is a bubble. E still holds.
- Illegal opcodes propagate to W with bit0=1 so a later exception stage can act on them.

## Test plan
- Reset: instrD=0x8D280000 (LW $8,0($9)) held with rst=1 for 2 cycles → ctrlE/M/W=0, writereg*=0, lu_stall=0.
- Pipeline flow: LW $8,0($9), then ADD $10,$8,$0 (0x01005020).
  - Cycle 1: ctrlE=0x1480, writeregE=8, lu_stall=1.
  - Cycle 2: ctrlM=0x1480. If flushE was driven, ctrlE=0.
  - Cycle 3: ctrlW=0x1480.
- Sub-word decode: LB → 0x148A, LHU → 0x1484, SB → 0x0508, ORI → 0x1430, J → 0x0040.
- Stall and flush:
  - ADD in E, stallE=1 for 2 cycles → ctrlE holds 0x1820 and ctrlM=0 both cycles.
  - stallE=1 with flushE=1 → ctrlE=0.
- Parameter variants:
  - `EXT_MEM`=0: LB → ctrlE=0x0001.
  - `LU_DETECT`=0: the load-use sequence above gives lu_stall=0.
- Zero register: LW $0,0($9) followed by a reader of $0 → lu_stall=0.

Source files
------------

// File: rtl/maindec_pipe.sv
// Main decoder for the 5-stage MIPS core: decodes the D-stage opcode into a
// 13-bit control word and carries it with the destination register through E/M/W.
module maindec_pipe #(
  parameter bit LU_DETECT = 1'b1,
  parameter bit EXT_MEM   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instrD,
  input  logic        stallE,
  input  logic        flushE,
  input  logic        flushM,
  output logic [12:0] ctrlE,
  output logic [12:0] ctrlM,
  output logic [12:0] ctrlW,
  output logic [4:0]  writeregE,
  output logic [4:0]  writeregM,
  output logic [4:0]  writeregW,
  output logic        lu_stall
);

  localparam int unsigned CW         = 13;
  localparam int unsigned RW         = 5;
  localparam int unsigned REGDST_BIT = 11;
  localparam int unsigned MEMTOREG   = 7;

  localparam logic [CW-1:0] CW_BUBBLE  = 13'h0000;
  localparam logic [CW-1:0] CW_ILLEGAL = 13'h0001;
  localparam logic [CW-1:0] CW_RTYPE   = 13'h1820;
  localparam logic [CW-1:0] CW_LW      = 13'h1480;
  localparam logic [CW-1:0] CW_LH      = 13'h1486;
  localparam logic [CW-1:0] CW_LHU     = 13'h1484;
  localparam logic [CW-1:0] CW_LB      = 13'h148A;
  localparam logic [CW-1:0] CW_LBU     = 13'h1488;
  localparam logic [CW-1:0] CW_SW      = 13'h0500;
  localparam logic [CW-1:0] CW_SH      = 13'h0504;
  localparam logic [CW-1:0] CW_SB      = 13'h0508;
  localparam logic [CW-1:0] CW_BEQ     = 13'h0210;
  localparam logic [CW-1:0] CW_J       = 13'h0040;
  localparam logic [CW-1:0] CW_IMM_ADD = 13'h1400;
  localparam logic [CW-1:0] CW_IMM_LOG = 13'h1430;

  logic [5:0]    op;
  logic [RW-1:0] rs;
  logic [RW-1:0] rt;
  logic [RW-1:0] rd;
  logic [CW-1:0] ctrl_d;
  logic [RW-1:0] writereg_d;
  logic          unused_instr_bits;

  assign op = instrD[31:26];
  assign rs = instrD[25:21];
  assign rt = instrD[20:16];
  assign rd = instrD[15:11];
  assign unused_instr_bits = ^instrD[10:0];

  // Opcode decode; sub-word memory ops fall back to illegal without EXT_MEM.
  always_comb begin
    ctrl_d = CW_ILLEGAL;
    case (op)
      6'b000000: ctrl_d = CW_RTYPE;
      6'b100011: ctrl_d = CW_LW;
      6'b100001: ctrl_d = EXT_MEM ? CW_LH  : CW_ILLEGAL;
      6'b100101: ctrl_d = EXT_MEM ? CW_LHU : CW_ILLEGAL;
      6'b100000: ctrl_d = EXT_MEM ? CW_LB  : CW_ILLEGAL;
      6'b100100: ctrl_d = EXT_MEM ? CW_LBU : CW_ILLEGAL;
      6'b101011: ctrl_d = CW_SW;
      6'b101001: ctrl_d = EXT_MEM ? CW_SH  : CW_ILLEGAL;
      6'b101000: ctrl_d = EXT_MEM ? CW_SB  : CW_ILLEGAL;
      6'b000100: ctrl_d = CW_BEQ;
      6'b000010: ctrl_d = CW_J;
      6'b001000, 6'b001001, 6'b001010, 6'b001011: ctrl_d = CW_IMM_ADD;
      6'b001100, 6'b001101, 6'b001110, 6'b001111: ctrl_d = CW_IMM_LOG;
      default:   ctrl_d = CW_ILLEGAL;
    endcase
  end

  assign writereg_d = ctrl_d[REGDST_BIT] ? rd : rt;

  // E stage: flush beats stall; stall holds.
  always_ff @(posedge clk) begin
    if (rst || flushE) begin
      ctrlE     <= CW_BUBBLE;
      writeregE <= RW'(0);
    end else if (!stallE) begin
      ctrlE     <= ctrl_d;
      writeregE <= writereg_d;
    end
  end

  // M stage: a stalled E must not duplicate into M, so stall inserts a bubble.
  always_ff @(posedge clk) begin
    if (rst || flushM || stallE) begin
      ctrlM     <= CW_BUBBLE;
      writeregM <= RW'(0);
    end else begin
      ctrlM     <= ctrlE;
      writeregM <= writeregE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrlW     <= CW_BUBBLE;
      writeregW <= RW'(0);
    end else begin
      ctrlW     <= ctrlM;
      writeregW <= writeregM;
    end
  end

  // Conservative load-use check: rt is compared even if D does not read it.
  assign lu_stall = LU_DETECT && ctrlE[MEMTOREG] && (writeregE != RW'(0)) &&
                    ((writeregE == rs) || (writeregE == rt));

endmodule

// File: tb/tb_maindec_pipe.sv
// Scoreboard bench for maindec_pipe: three parameter variants driven in lockstep
// and checked against a table-driven pipeline model.
module tb_maindec_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        stall_e;
  logic        flush_e;
  logic        flush_m;

  logic [2:0][12:0] ctrl_e, ctrl_m, ctrl_w;
  logic [2:0][4:0]  wr_e, wr_m, wr_w;
  logic [2:0]       lu;

  always #5 clk = ~clk;

  // Variant 0: full; 1: EXT_MEM=0; 2: LU_DETECT=0.
  localparam bit [2:0] V_EXT = 3'b101;
  localparam bit [2:0] V_LUD = 3'b011;

  maindec_pipe #(.LU_DETECT(1'b1), .EXT_MEM(1'b1)) dut0 (
    .clk(clk), .rst(rst), .instrD(instr), .stallE(stall_e), .flushE(flush_e), .flushM(flush_m),
    .ctrlE(ctrl_e[0]), .ctrlM(ctrl_m[0]), .ctrlW(ctrl_w[0]),
    .writeregE(wr_e[0]), .writeregM(wr_m[0]), .writeregW(wr_w[0]), .lu_stall(lu[0]));

  maindec_pipe #(.LU_DETECT(1'b1), .EXT_MEM(1'b0)) dut1 (
    .clk(clk), .rst(rst), .instrD(instr), .stallE(stall_e), .flushE(flush_e), .flushM(flush_m),
    .ctrlE(ctrl_e[1]), .ctrlM(ctrl_m[1]), .ctrlW(ctrl_w[1]),
    .writeregE(wr_e[1]), .writeregM(wr_m[1]), .writeregW(wr_w[1]), .lu_stall(lu[1]));

  maindec_pipe #(.LU_DETECT(1'b0), .EXT_MEM(1'b1)) dut2 (
    .clk(clk), .rst(rst), .instrD(instr), .stallE(stall_e), .flushE(flush_e), .flushM(flush_m),
    .ctrlE(ctrl_e[2]), .ctrlM(ctrl_m[2]), .ctrlW(ctrl_w[2]),
    .writeregE(wr_e[2]), .writeregM(wr_m[2]), .writeregW(wr_w[2]), .lu_stall(lu[2]));

  typedef struct packed {
    logic [2:0][2:0][12:0] ctrl;  // [variant][stage E/M/W]
    logic [2:0][2:0][4:0]  wr;
    logic [2:0]            lu;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Model state per variant and stage (0=E, 1=M, 2=W).
  logic [12:0] m_ctrl[3][3];
  logic [4:0]  m_wr[3][3];
  bit          m_valid = 1'b0;

  function automatic logic [12:0] ref_dec(input logic [5:0] op, input bit ext);
    case (op)
      6'h00: return 13'h1820;
      6'h23: return 13'h1480;
      6'h21: return ext ? 13'h1486 : 13'h0001;
      6'h25: return ext ? 13'h1484 : 13'h0001;
      6'h20: return ext ? 13'h148A : 13'h0001;
      6'h24: return ext ? 13'h1488 : 13'h0001;
      6'h2B: return 13'h0500;
      6'h29: return ext ? 13'h0504 : 13'h0001;
      6'h28: return ext ? 13'h0508 : 13'h0001;
      6'h04: return 13'h0210;
      6'h02: return 13'h0040;
      6'h08, 6'h09, 6'h0A, 6'h0B: return 13'h1400;
      6'h0C, 6'h0D, 6'h0E, 6'h0F: return 13'h1430;
      default: return 13'h0001;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'h000};
  endfunction

  // Drive one cycle of inputs, record expectations for this cycle, advance the model.
  task automatic step(input logic [31:0] i, input bit st, input bit fe, input bit fm, input bit r);
    exp_t        e;
    logic [12:0] dc;
    logic [4:0]  rs_d, rt_d;
    instr = i; stall_e = st; flush_e = fe; flush_m = fm; rst = r;
    rs_d = i[25:21];
    rt_d = i[20:16];
    if (m_valid) begin
      for (int v = 0; v < 3; v++) begin
        for (int s = 0; s < 3; s++) begin
          e.ctrl[v][s] = m_ctrl[v][s];
          e.wr[v][s]   = m_wr[v][s];
        end
        e.lu[v] = V_LUD[v] && m_ctrl[v][0][7] && (m_wr[v][0] != 5'd0) &&
                  (m_wr[v][0] == rs_d || m_wr[v][0] == rt_d);
      end
      exp_q.push_back(e);
    end
    for (int v = 0; v < 3; v++) begin
      if (r) begin
        for (int s = 0; s < 3; s++) begin m_ctrl[v][s] = '0; m_wr[v][s] = '0; end
      end else begin
        m_ctrl[v][2] = m_ctrl[v][1]; m_wr[v][2] = m_wr[v][1];
        if (fm || st) begin m_ctrl[v][1] = '0; m_wr[v][1] = '0; end
        else begin m_ctrl[v][1] = m_ctrl[v][0]; m_wr[v][1] = m_wr[v][0]; end
        if (fe) begin m_ctrl[v][0] = '0; m_wr[v][0] = '0; end
        else if (!st) begin
          dc = ref_dec(i[31:26], V_EXT[v]);
          m_ctrl[v][0] = dc;
          m_wr[v][0]   = dc[11] ? i[15:11] : i[20:16];
        end
      end
    end
    if (r) m_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int v, input logic [12:0] act, input logic [12:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s variant%0d at %0t: got %h expected %h", name, v, $time, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare each against the next queued entry.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      for (int v = 0; v < 3; v++) begin
        chk("ctrlE", v, ctrl_e[v], e.ctrl[v][0]);
        chk("ctrlM", v, ctrl_m[v], e.ctrl[v][1]);
        chk("ctrlW", v, ctrl_w[v], e.ctrl[v][2]);
        chk("writeregE", v, 13'(wr_e[v]), 13'(e.wr[v][0]));
        chk("writeregM", v, 13'(wr_m[v]), 13'(e.wr[v][1]));
        chk("writeregW", v, 13'(wr_w[v]), 13'(e.wr[v][2]));
        chk("lu_stall", v, 13'(lu[v]), 13'(e.lu[v]));
      end
    end
  end

  logic [5:0] op_pool[20] = '{6'h00, 6'h23, 6'h21, 6'h25, 6'h20, 6'h24, 6'h2B, 6'h29, 6'h28,
                              6'h04, 6'h02, 6'h08, 6'h0A, 6'h0C, 6'h0F, 6'h03, 6'h3F, 6'h23,
                              6'h20, 6'h00};

  initial begin
    logic [31:0] lw8, add10;
    logic [5:0]  op;
    lw8   = 32'h8D280000;
    add10 = 32'h01005020;

    // Reset held for two cycles with LW in D.
    step(lw8, 0, 0, 0, 1);
    step(lw8, 0, 0, 0, 1);
    // Load-use flow, then flushE on the dependent instruction.
    step(lw8, 0, 0, 0, 0);
    step(add10, 0, 1, 0, 0);
    step(add10, 0, 0, 0, 0);
    step(mk(6'h00, 0, 0, 0), 0, 0, 0, 0);
    step(mk(6'h00, 0, 0, 0), 0, 0, 0, 0);
    // Sub-word decode and immediates.
    step(mk(6'h20, 1, 2, 0), 0, 0, 0, 0);
    step(mk(6'h25, 3, 4, 0), 0, 0, 0, 0);
    step(mk(6'h28, 5, 6, 0), 0, 0, 0, 0);
    step(mk(6'h0D, 7, 9, 0), 0, 0, 0, 0);
    step(mk(6'h02, 0, 0, 0), 0, 0, 0, 0);
    step(mk(6'h3F, 1, 1, 1), 0, 0, 0, 0);
    // ADD in E, stalled two cycles, then stall+flushE, then flushM+stallE.
    step(add10, 0, 0, 0, 0);
    step(lw8, 1, 0, 0, 0);
    step(lw8, 1, 0, 0, 0);
    step(lw8, 1, 1, 0, 0);
    step(add10, 0, 0, 0, 0);
    step(lw8, 1, 0, 1, 0);
    step(lw8, 0, 0, 0, 0);
    // Load into $0 followed by a reader of $0.
    step(mk(6'h23, 9, 0, 0), 0, 0, 0, 0);
    step(mk(6'h00, 0, 0, 10), 0, 0, 0, 0);
    step(mk(6'h00, 0, 0, 10), 0, 0, 0, 0);
    // Mid-stream reset.
    step(lw8, 0, 0, 0, 1);
    step(add10, 0, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 19)];
      step(mk(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))),
           $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 63) == 0);
    end

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
